htu_req_queue: RTL and testbench

Per-bank request queue sitting directly downstream of the crossbar's bank-side request port (xbar_bankN_htu_*). It buffers crossbar requests in order and issues them to the bank's hit-test pipeline. It blocks same-line requests with an outstanding-address table: a request is not issued while an earlier request to the same 16-byte line is still in flight in the pipeline. One instance per bank.

---
 rtl/htu_req_queue.sv | 143 ++++++++++++++
 tb/tb_htu_req_queue.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/htu_req_queue.sv
// Per-bank in-order request queue with an outstanding-line table that holds
// same-line requests back; same-cycle bypass when HTU_REQ_BYPASS_EN is defined.
module htu_req_queue #(
  parameter int DEPTH   = 4,
  parameter int OST_NUM = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int SW = $clog2(OST_NUM)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          xbar_htu_valid_i,
  output logic          xbar_htu_allowIn_o,
  input  logic [1:0]    xbar_htu_ch_id_i,
  input  logic [1:0]    xbar_htu_opcode_i,
  input  logic [27:0]   xbar_htu_addr_i,
  input  logic [7:0]    xbar_htu_wbuffer_id_i,
  output logic          htu_pipe_valid_o,
  input  logic          htu_pipe_ready_i,
  output logic [1:0]    htu_pipe_ch_id_o,
  output logic [1:0]    htu_pipe_opcode_o,
  output logic [27:0]   htu_pipe_addr_o,
  output logic [7:0]    htu_pipe_wbuffer_id_o,
  output logic [SW-1:0] htu_pipe_slot_o,
  input  logic          htu_done_valid_i,
  input  logic [SW-1:0] htu_done_slot_i,
  output logic [AW:0]   queue_cnt_o
);

  typedef struct packed {
    logic [1:0]  ch_id;
    logic [1:0]  opcode;
    logic [27:0] addr;
    logic [7:0]  wbuffer_id;
  } req_t;

  req_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          ost_vld [OST_NUM];
  logic [27:0]   ost_addr [OST_NUM];

  req_t          head;
  req_t          in_req;
  logic          empty;
  logic          hazard;
  logic          free_ok;
  logic [SW-1:0] free_idx;
  logic          fifo_rdy;
  logic          byp;
  logic          push;
  logic          fifo_pop;
  logic          issue;

  assign head   = mem[rd_ptr];
  assign in_req = '{ch_id:      xbar_htu_ch_id_i,
                    opcode:     xbar_htu_opcode_i,
                    addr:       xbar_htu_addr_i,
                    wbuffer_id: xbar_htu_wbuffer_id_i};
  assign empty  = (count == '0);

  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < OST_NUM; i++)
      if (ost_vld[i] && ost_addr[i] == head.addr)
        hazard = 1'b1;
  end

  // Scan downward so the lowest free index wins.
  always_comb begin
    free_ok  = 1'b0;
    free_idx = '0;
    for (int i = OST_NUM - 1; i >= 0; i--)
      if (!ost_vld[i]) begin
        free_ok  = 1'b1;
        free_idx = SW'(i);
      end
  end

`ifdef HTU_REQ_BYPASS_EN
  logic in_hit;

  always_comb begin
    in_hit = 1'b0;
    for (int i = 0; i < OST_NUM; i++)
      if (ost_vld[i] && ost_addr[i] == xbar_htu_addr_i)
        in_hit = 1'b1;
  end

  assign byp = empty && xbar_htu_valid_i && free_ok && !in_hit;
`else
  assign byp = 1'b0;
`endif

  assign xbar_htu_allowIn_o = (count != (AW+1)'(DEPTH));
  assign fifo_rdy  = !empty && !hazard && free_ok;
  assign htu_pipe_valid_o = fifo_rdy || byp;
  assign issue     = htu_pipe_valid_o && htu_pipe_ready_i;
  assign fifo_pop  = fifo_rdy && htu_pipe_ready_i;
  assign push      = xbar_htu_valid_i && xbar_htu_allowIn_o
                   && !(byp && htu_pipe_ready_i);

  assign htu_pipe_ch_id_o      = byp ? in_req.ch_id      : head.ch_id;
  assign htu_pipe_opcode_o     = byp ? in_req.opcode     : head.opcode;
  assign htu_pipe_addr_o       = byp ? in_req.addr       : head.addr;
  assign htu_pipe_wbuffer_id_o = byp ? in_req.wbuffer_id : head.wbuffer_id;
  assign htu_pipe_slot_o       = free_idx;
  assign queue_cnt_o           = count;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
      for (int i = 0; i < OST_NUM; i++) begin
        ost_vld[i]  <= 1'b0;
        ost_addr[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_req;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (fifo_pop)
        rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, fifo_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // Allocation targets a free slot, so it never collides with a live retire.
      if (htu_done_valid_i)
        ost_vld[htu_done_slot_i] <= 1'b0;
      if (issue) begin
        ost_vld[free_idx]  <= 1'b1;
        ost_addr[free_idx] <= htu_pipe_addr_o;
      end
    end
  end

endmodule

// File: tb/tb_htu_req_queue.sv
// Directed bench for htu_req_queue: FIFO order, line hazards, slot
// allocation, full-queue blocking, async reset and optional bypass.
module tb_htu_req_queue;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        xbar_htu_valid_i = 1'b0;
  logic        xbar_htu_allowIn_o;
  logic [1:0]  xbar_htu_ch_id_i = '0;
  logic [1:0]  xbar_htu_opcode_i = '0;
  logic [27:0] xbar_htu_addr_i = '0;
  logic [7:0]  xbar_htu_wbuffer_id_i = '0;
  logic        htu_pipe_valid_o;
  logic        htu_pipe_ready_i = 1'b0;
  logic [1:0]  htu_pipe_ch_id_o;
  logic [1:0]  htu_pipe_opcode_o;
  logic [27:0] htu_pipe_addr_o;
  logic [7:0]  htu_pipe_wbuffer_id_o;
  logic [1:0]  htu_pipe_slot_o;
  logic        htu_done_valid_i = 1'b0;
  logic [1:0]  htu_done_slot_i = '0;
  logic [2:0]  queue_cnt_o;

  int vectors = 0;
  int miscompares = 0;

  htu_req_queue #(.DEPTH(4), .OST_NUM(4)) dut (
    .clk_i                 (clk_i),
    .rst_i                 (rst_i),
    .xbar_htu_valid_i      (xbar_htu_valid_i),
    .xbar_htu_allowIn_o    (xbar_htu_allowIn_o),
    .xbar_htu_ch_id_i      (xbar_htu_ch_id_i),
    .xbar_htu_opcode_i     (xbar_htu_opcode_i),
    .xbar_htu_addr_i       (xbar_htu_addr_i),
    .xbar_htu_wbuffer_id_i (xbar_htu_wbuffer_id_i),
    .htu_pipe_valid_o      (htu_pipe_valid_o),
    .htu_pipe_ready_i      (htu_pipe_ready_i),
    .htu_pipe_ch_id_o      (htu_pipe_ch_id_o),
    .htu_pipe_opcode_o     (htu_pipe_opcode_o),
    .htu_pipe_addr_o       (htu_pipe_addr_o),
    .htu_pipe_wbuffer_id_o (htu_pipe_wbuffer_id_o),
    .htu_pipe_slot_o       (htu_pipe_slot_o),
    .htu_done_valid_i      (htu_done_valid_i),
    .htu_done_slot_i       (htu_done_slot_i),
    .queue_cnt_o           (queue_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic req(input logic [27:0] a, input logic [1:0] ch,
                     input logic [7:0] wb);
    xbar_htu_valid_i      = 1'b1;
    xbar_htu_addr_i       = a;
    xbar_htu_ch_id_i      = ch;
    xbar_htu_opcode_i     = ch ^ 2'b11;
    xbar_htu_wbuffer_id_i = wb;
  endtask

  task automatic retire(input logic [1:0] s);
    htu_done_valid_i = 1'b1;
    htu_done_slot_i  = s;
    step();
    htu_done_valid_i = 1'b0;
  endtask

  initial begin
    #1;
    chk("rst_allow", 32'(xbar_htu_allowIn_o), 32'd1);
    chk("rst_valid", 32'(htu_pipe_valid_o), 32'd0);
    chk("rst_cnt", 32'(queue_cnt_o), 32'd0);
    chk("rst_slot", 32'(htu_pipe_slot_o), 32'd0);
    chk("rst_addr", 32'(htu_pipe_addr_o), 32'd0);
    step();
    rst_i = 1'b1;
    step();

    // Fill with ready low, then drain in order.
    for (int i = 0; i < 4; i++) begin
      req(28'(32'h100 * (i + 1)), 2'(i), 8'(8'hA0 + i));
      step();
    end
    chk("fill_cnt", 32'(queue_cnt_o), 32'd4);
    chk("fill_allow", 32'(xbar_htu_allowIn_o), 32'd0);
    req(28'h500, 2'd0, 8'hFF);
    step();
    chk("full_cnt", 32'(queue_cnt_o), 32'd4);
    xbar_htu_valid_i = 1'b0;
    htu_pipe_ready_i = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_vld", 32'(htu_pipe_valid_o), 32'd1);
      chk("drain_addr", 32'(htu_pipe_addr_o), 32'h100 * (i + 1));
      chk("drain_slot", 32'(htu_pipe_slot_o), 32'(i));
      chk("drain_ch", 32'(htu_pipe_ch_id_o), 32'(i));
      chk("drain_wb", 32'(htu_pipe_wbuffer_id_o), 32'hA0 + 32'(i));
      step();
    end
    chk("drain_cnt", 32'(queue_cnt_o), 32'd0);
    htu_pipe_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) retire(2'(i));

    // Same-line hazard.
    req(28'h0ABC, 2'd1, 8'h11);
    step();
    req(28'h0ABC, 2'd2, 8'h22);
    step();
    xbar_htu_valid_i = 1'b0;
    htu_pipe_ready_i = 1'b1;
    #1;
    chk("haz_first_vld", 32'(htu_pipe_valid_o), 32'd1);
    chk("haz_first_slot", 32'(htu_pipe_slot_o), 32'd0);
    step();
    chk("haz_block", 32'(htu_pipe_valid_o), 32'd0);
    chk("haz_cnt", 32'(queue_cnt_o), 32'd1);
    step();
    chk("haz_block2", 32'(htu_pipe_valid_o), 32'd0);
    htu_done_valid_i = 1'b1;
    htu_done_slot_i  = 2'd0;
    #1;
    chk("haz_retire_cyc", 32'(htu_pipe_valid_o), 32'd0);
    step();
    htu_done_valid_i = 1'b0;
    #1;
    chk("haz_release", 32'(htu_pipe_valid_o), 32'd1);
    chk("haz_slot", 32'(htu_pipe_slot_o), 32'd0);
    chk("haz_wb", 32'(htu_pipe_wbuffer_id_o), 32'h22);
    step();
    chk("haz_cnt0", 32'(queue_cnt_o), 32'd0);
    htu_pipe_ready_i = 1'b0;
    retire(2'd0);

    // Exhaust the outstanding table.
    htu_pipe_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req(28'(32'h1000 + i), 2'd0, 8'(i));
      step();
    end
    xbar_htu_valid_i = 1'b0;
    step();
    chk("ost_drained", 32'(queue_cnt_o), 32'd0);
    req(28'h2000, 2'd3, 8'h33);
    step();
    xbar_htu_valid_i = 1'b0;
    #1;
    chk("ost_full_vld", 32'(htu_pipe_valid_o), 32'd0);
    chk("ost_full_cnt", 32'(queue_cnt_o), 32'd1);
    htu_done_valid_i = 1'b1;
    htu_done_slot_i  = 2'd2;
    #1;
    chk("ost_retire_cyc", 32'(htu_pipe_valid_o), 32'd0);
    step();
    htu_done_valid_i = 1'b0;
    #1;
    chk("ost_free_vld", 32'(htu_pipe_valid_o), 32'd1);
    chk("ost_free_slot", 32'(htu_pipe_slot_o), 32'd2);
    chk("ost_free_addr", 32'(htu_pipe_addr_o), 32'h2000);
    step();
    htu_pipe_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) retire(2'(i));

    // Full queue with simultaneous dequeue and enqueue.
    for (int i = 0; i < 4; i++) begin
      req(28'(32'h3000 + i), 2'd0, 8'(i));
      step();
    end
    req(28'h3004, 2'd0, 8'h44);
    htu_pipe_ready_i = 1'b1;
    #1;
    chk("fd_allow", 32'(xbar_htu_allowIn_o), 32'd0);
    step();
    htu_pipe_ready_i = 1'b0;
    #1;
    chk("fd_cnt3", 32'(queue_cnt_o), 32'd3);
    step();
    xbar_htu_valid_i = 1'b0;
    #1;
    chk("fd_cnt4", 32'(queue_cnt_o), 32'd4);
    chk("fd_head", 32'(htu_pipe_addr_o), 32'h3001);

    // Async reset with queued and outstanding state.
    htu_pipe_ready_i = 1'b1;
    step();
    htu_pipe_ready_i = 1'b0;
    #1;
    chk("pre_rst_cnt", 32'(queue_cnt_o), 32'd3);
    rst_i = 1'b0;
    #1;
    chk("mid_rst_cnt", 32'(queue_cnt_o), 32'd0);
    chk("mid_rst_vld", 32'(htu_pipe_valid_o), 32'd0);
    chk("mid_rst_allow", 32'(xbar_htu_allowIn_o), 32'd1);
    step();
    rst_i = 1'b1;
    step();
    req(28'h3000, 2'd1, 8'h55);
    step();
    xbar_htu_valid_i = 1'b0;
    #1;
    chk("post_rst_vld", 32'(htu_pipe_valid_o), 32'd1);
    chk("post_rst_addr", 32'(htu_pipe_addr_o), 32'h3000);
    chk("post_rst_slot", 32'(htu_pipe_slot_o), 32'd0);
    htu_pipe_ready_i = 1'b1;
    step();
    chk("post_rst_cnt", 32'(queue_cnt_o), 32'd0);

    // Empty-queue latency; slot 0 still holds 0x3000.
    req(28'h55, 2'd2, 8'h66);
    #1;
`ifdef HTU_REQ_BYPASS_EN
    chk("byp_vld", 32'(htu_pipe_valid_o), 32'd1);
    chk("byp_addr", 32'(htu_pipe_addr_o), 32'h55);
    chk("byp_slot", 32'(htu_pipe_slot_o), 32'd1);
    step();
    xbar_htu_valid_i = 1'b0;
    #1;
    chk("byp_cnt", 32'(queue_cnt_o), 32'd0);
    chk("byp_after", 32'(htu_pipe_valid_o), 32'd0);
`else
    chk("lat_vld0", 32'(htu_pipe_valid_o), 32'd0);
    step();
    xbar_htu_valid_i = 1'b0;
    #1;
    chk("lat_vld1", 32'(htu_pipe_valid_o), 32'd1);
    chk("lat_addr", 32'(htu_pipe_addr_o), 32'h55);
    chk("lat_slot", 32'(htu_pipe_slot_o), 32'd1);
    chk("lat_cnt1", 32'(queue_cnt_o), 32'd1);
    step();
    chk("lat_cnt0", 32'(queue_cnt_o), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
